// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: requester handshakes (fetch m0, LSU m1) and RAM port for ram_port_arbiter.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic [ADDR_W-1:0] m0_addr;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;
  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [2:0]        m1_width;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;
  logic              busy;
  logic [ADDR_W-1:0] ram_addra;
  logic [DATA_W-1:0] ram_dina;
  logic              ram_wea;
  logic [2:0]        ram_u_b_h_w;
  logic [DATA_W-1:0] ram_douta;
  modport slave (
    input  m0_req, m0_addr, m1_req, m1_we, m1_addr, m1_wdata, m1_width, ram_douta,
    output m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata, busy,
           ram_addra, ram_dina, ram_wea, ram_u_b_h_w
  );
  modport master (
    output m0_req, m0_addr, m1_req, m1_we, m1_addr, m1_wdata, m1_width, ram_douta,
    input  m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata, busy,
           ram_addra, ram_dina, ram_wea, ram_u_b_h_w
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one byte-addressed RAM between fetch (m0) and LSU (m1), IDLE->ACCESS->RESP.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise m1 always wins a tie.
module ram_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic clk,
  input logic rst,
  ram_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_m0_rdata;
  logic [DATA_W-1:0] r_m1_rdata;
  logic [2:0]        r_width;
  logic              r_we;
  logic              r_wea;
  logic              r_owner;
  logic              r_m0_gnt;
  logic              r_m1_gnt;
  logic              r_m0_rvalid;
  logic              r_m1_rvalid;
  logic              r_busy;
  logic              w_any;
  logic              w_pick1;
  logic              w_m1_pri;
`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic              r_last;
  assign w_m1_pri = ~r_last;
`else
  assign w_m1_pri = 1'b1;
`endif
  assign w_any   = bus.m0_req | bus.m1_req;
  assign w_pick1 = bus.m1_req & (~bus.m0_req | w_m1_pri);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_width     <= '0;
      r_we        <= 1'b0;
      r_wea       <= 1'b0;
      r_owner     <= 1'b0;
      r_m0_gnt    <= 1'b0;
      r_m1_gnt    <= 1'b0;
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      r_busy      <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      r_last      <= 1'b0;
`endif
    end else begin
      r_m0_gnt    <= 1'b0;
      r_m1_gnt    <= 1'b0;
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      r_wea       <= 1'b0;
      if (r_state == ACCESS) begin
        r_state     <= RESP;
        r_m0_rvalid <= ~r_owner;
        r_m1_rvalid <= r_owner;
        if (!r_we && !r_owner) r_m0_rdata <= bus.ram_douta;
        if (!r_we && r_owner) r_m1_rdata <= bus.ram_douta;
      end else if (w_any) begin
        // fetch is read-only word access; its store-data path keeps the previous value
        r_state  <= ACCESS;
        r_busy   <= 1'b1;
        r_owner  <= w_pick1;
        r_addr   <= w_pick1 ? bus.m1_addr : bus.m0_addr;
        r_wdata  <= w_pick1 ? bus.m1_wdata : r_wdata;
        r_width  <= w_pick1 ? bus.m1_width : 3'b010;
        r_we     <= w_pick1 & bus.m1_we;
        r_wea    <= w_pick1 & bus.m1_we;
        r_m0_gnt <= ~w_pick1;
        r_m1_gnt <= w_pick1;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        r_last   <= w_pick1;
`endif
      end else begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end
    end
  end
  assign bus.m0_gnt      = r_m0_gnt;
  assign bus.m1_gnt      = r_m1_gnt;
  assign bus.m0_rvalid   = r_m0_rvalid;
  assign bus.m1_rvalid   = r_m1_rvalid;
  assign bus.m0_rdata    = r_m0_rdata;
  assign bus.m1_rdata    = r_m1_rdata;
  assign bus.busy        = r_busy;
  assign bus.ram_addra   = r_addr;
  assign bus.ram_dina    = r_wdata;
  assign bus.ram_wea     = r_wea;
  assign bus.ram_u_b_h_w = r_width;
endmodule
